// File: rtl/mat_stream_loader.sv
// Serial-to-parallel operand loader for the matmat<N> multiplier: gathers A and B
// one element per beat, runs the multiplier's start protocol and holds the product.
module mat_stream_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int BIN_POS     = 16,
  parameter int MATRIX_SIZE = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [DATA_WIDTH-1:0]                           in_data,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   matrix_a,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   matrix_b,
  output logic                                            mm_rst,
  input  logic                                            mm_ready,
  input  logic                                            mm_complete,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   mm_mul,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]   result,
  output logic                                            result_valid,
  input  logic                                            result_ack,
  output logic [CNT_WIDTH-1:0]                            run_cycles
);

  localparam int NE    = MATRIX_SIZE * MATRIX_SIZE;
  localparam int IDX_W = $clog2(2 * NE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * NE - 1);

  // Element values are carried untouched; the binary point only needs to fit the word.
  if (BIN_POS < 0 || BIN_POS >= DATA_WIDTH) begin : g_bin_pos_check
    $error("BIN_POS must lie within DATA_WIDTH");
  end

  typedef enum logic [1:0] {LOAD, ARM, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx;
  logic [CNT_WIDTH-1:0] cnt, cnt_inc;
  logic                 beat;

  assign in_ready = (state == LOAD);
  assign beat     = in_valid && in_ready;
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (beat && idx == IDX_LAST) state_nxt = ARM;
      ARM:  if (mm_ready)                state_nxt = RUN;
      RUN:  if (mm_complete)             state_nxt = DONE;
      DONE: if (result_ack)              state_nxt = LOAD;
      default:                           state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx          <= '0;
      matrix_a     <= '0;
      matrix_b     <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      run_cycles   <= '0;
      mm_rst       <= 1'b1;
      cnt          <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (beat) begin
            // Decode idx into A elements 0..NE-1, then B elements NE..2*NE-1.
            for (int unsigned i = 0; i < NE; i++) begin
              if (idx == IDX_W'(i))      matrix_a[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
              if (idx == IDX_W'(NE + i)) matrix_b[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          end
        end
        ARM: begin
          if (mm_ready) begin
            mm_rst <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (mm_complete) begin
            result       <= mm_mul;
            result_valid <= 1'b1;
            run_cycles   <= cnt_inc;
            mm_rst       <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          if (result_ack) result_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mat_stream_loader.md
# mat_stream_loader

Upstream feeder for the `matmat<N>` fixed-point matrix multiplier. It assembles operand matrices A and B from a one-element-per-beat valid/ready stream and drives the multiplier's `rst`/`ready`/`complete` start protocol. It captures the product into a held result register and reports the run length in cycles. It lets a serial source, such as a navigation filter sequencer, reuse one multiplier instance without driving wide parallel buses.

## Interface
- `DATA_WIDTH`, 32, element width in bits (two's-complement fixed point).
- `BIN_POS`, 16, binary point position. Passed through only; no arithmetic is done on element values.
- `MATRIX_SIZE`, 3, N; each matrix holds N*N elements.
- `CNT_WIDTH`, 16, width of `run_cycles`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  source has an element on `in_data`.
- `in_ready`  out  1  block accepts an element this cycle.
- `in_data`  in  DATA_WIDTH  element value.
- `matrix_a`  out  N*N*DATA_WIDTH  operand A to the multiplier; element i at `[i*DATA_WIDTH +: DATA_WIDTH]`, row-major.
- `matrix_b`  out  N*N*DATA_WIDTH  operand B to the multiplier, same packing as `matrix_a`.
- `mm_rst`  out  1  drives the multiplier `rst`; high means held/idle.
- `mm_ready`  in  1  multiplier `ready`.
- `mm_complete`  in  1  multiplier `complete`.
- `mm_mul`  in  N*N*DATA_WIDTH  multiplier product.
- `result`  out  N*N*DATA_WIDTH  captured product.
- `result_valid`  out  1  `result` holds a new, unacknowledged product.
- `result_ack`  in  1  consumer takes `result`.
- `run_cycles`  out  CNT_WIDTH  cycles from the `mm_rst` fall to `mm_complete` for the last run; saturates at all-ones.

## Operation
- States:
  - LOAD: accepting elements.
  - ARM: waiting for `mm_ready`.
  - RUN: multiplier active.
  - DONE: result held.
- Reset values:
  - State LOAD; element index `idx` = 0.
  - `matrix_a`, `matrix_b`, `result` = 0.
  - `result_valid` = 0; `run_cycles` = 0; `mm_rst` = 1.
- `in_ready` = (state == LOAD). It is combinational from registered state, so it is 1 in the first cycle after reset releases.
- LOAD:
  - On each beat (`in_valid && in_ready`), `idx` in 0..N*N-1 writes `matrix_a` element `idx`.
  - `idx` in N*N..2*N*N-1 writes `matrix_b` element `idx`-N*N.
  - `idx` then increments.
  - On the beat with `idx` = 2*N*N-1, `idx` wraps to 0 and the state goes to ARM.
  - Elements not rewritten keep their value from the previous load.
- ARM: `mm_rst` stays 1. When `mm_ready` is sampled 1, `mm_rst` goes 0 at that edge, the run counter clears to 0, and the state goes to RUN.
- RUN:
  - `mm_rst` = 0; the run counter increments each cycle and saturates.
  - When `mm_complete` is sampled 1:
    - `result` <= `mm_mul`.
    - `result_valid` <= 1.
    - `run_cycles` <= counter + 1 (saturating).
    - `mm_rst` <= 1.
    - State goes to DONE.
  - `mm_complete` is ignored in every state other than RUN.
- DONE:
  - `matrix_a` and `matrix_b` stay stable; `in_ready` = 0.
  - When `result_ack` is 1: `result_valid` <= 0 and the state goes to LOAD.
  - `result_ack` while `result_valid` = 0 has no effect.
- `result` and `run_cycles` hold until the next capture.
- `matrix_a` and `matrix_b` are stable whenever `mm_rst` = 0.
- `rst` in any state returns all registers to their reset values at that edge. The multiplier is re-held via `mm_rst` = 1 and partial loads are discarded.

## Timing
- Load: 2*N*N accepted beats, at most one per cycle; source bubbles and stalls are allowed.
- ARM → RUN takes 1 edge after `mm_ready` is seen. If `mm_ready` is already 1 on entry to ARM, `mm_rst` falls on the next edge.
- Capture latency: `result_valid` rises on the edge that samples `mm_complete` = 1.
- Return to LOAD: 1 edge after `result_ack`. `in_ready` is 1 in the following cycle.
- Minimum total overhead beyond load and multiply is 3 cycles (ARM, capture, ack).

## Test plan
- Identity × B:
  - Stimulus (N=3, W=32, BIN_POS=16): A = I (`0x00010000` on the diagonal); B elements k<<16 for k = 0..8; ack immediately.
  - Response: `result` == `matrix_b`, `result_valid` pulses once, `mm_rst` low only during RUN.
- Backpressure and bubbles:
  - Stimulus: `in_valid` toggles 1,0,0,1,… over 18 beats.
  - Response: all 18 elements land at the correct packed offsets; exactly 18 beats are accepted; ARM is entered after beat 18.
- Late `mm_ready`:
  - Stimulus: hold `mm_ready` = 0 for 10 cycles after load.
  - Response: `mm_rst` stays 1 for those cycles and falls on the edge after `mm_ready` = 1. With a model multiplier completing after 7 cycles, `run_cycles` = 7.
- Delayed ack:
  - Stimulus: hold `result_ack` = 0 for 20 cycles; offer `in_valid` = 1 meanwhile.
  - Response: `in_ready` = 0 and no beats are accepted; `result` is stable; after ack, a second run produces A×B for the new data.
- Reset mid-load:
  - Stimulus: assert `rst` after 5 beats.
  - Response: next cycle `idx` = 0, matrices are 0, `mm_rst` = 1; a full 18-beat reload produces the correct product.
- Spurious `mm_complete`:
  - Stimulus: pulse `mm_complete` during LOAD and DONE.
  - Response: no capture and no state change.
